fetch_stage: RTL

//  Instruction-fetch stage: owns the program counter, drives the word address into the

---
 rtl/fetch_stage_pkg.sv | 12 +
 rtl/fetch_stage.sv | 91 +++++++++
 2 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode constants: bubble and terminator encodings plus the fetch FSM state.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the pc, presents it to a combinational imem and
// registers the returned word into IF/ID, with stall, redirect/flush and halt.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          PC_WIDTH  = 8,
  parameter int          CNT_WIDTH = 16,
  parameter logic [31:0] NOP       = NOP_WORD,
  parameter logic [31:0] TERM      = HALT_WORD
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic [PC_WIDTH-1:0]  imem_addr_o,
  input  logic [31:0]          imem_instr_i,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [PC_WIDTH-1:0]  redirect_pc_i,
  output logic [31:0]          ifid_instr_o,
  output logic [PC_WIDTH-1:0]  ifid_pc_o,
  output logic                 ifid_valid_o,
  output logic                 halted_o,
  output logic [CNT_WIDTH-1:0] fetch_count_o
);

  fetch_state_e         state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [31:0]          ifid_instr_q, ifid_instr_d;
  logic [PC_WIDTH-1:0]  ifid_pc_q, ifid_pc_d;
  logic                 ifid_valid_q, ifid_valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Redirect beats everything, in either state; HALT otherwise freezes fetch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    cnt_d        = cnt_q;
    if (redirect_i) begin
      state_d      = RUN;
      pc_d         = redirect_pc_i;
      ifid_instr_d = NOP;
      ifid_valid_d = 1'b0;
    end else if (state_q == RUN && !stall_i) begin
      if (imem_instr_i == TERM) begin
        state_d      = HALT;
        ifid_instr_d = NOP;
        ifid_valid_d = 1'b0;
      end else begin
        pc_d         = pc_q + PC_WIDTH'(1);
        ifid_instr_d = imem_instr_i;
        ifid_pc_d    = pc_q;
        ifid_valid_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ifid_instr_q <= NOP;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign ifid_instr_o  = ifid_instr_q;
  assign ifid_pc_o     = ifid_pc_q;
  assign ifid_valid_o  = ifid_valid_q;
  assign halted_o      = (state_q == HALT);
  assign fetch_count_o = cnt_q;

endmodule
